// File: rtl/ox_result_sequencer.sv
// Round-result sequencer for the "P1 o" / "P2 X" 7-segment display: latches the winner,
// keeps saturating scores, and blinks then holds the o/x select lines (blink phase built only with OX_SEQ_BLINK_EN).
module ox_result_sequencer #(
    parameter int CLK_DIV = 25_000_000,
    parameter int BLINKS  = 3,
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               win_o_i,
    input  logic               win_x_i,
    input  logic               clear_i,
    output logic               o,
    output logic               x,
    output logic               busy,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] score_x
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW_ON  = 2'd1,
        SHOW_OFF = 2'd2,
        HOLD     = 2'd3
    } state_t;

    // Elaboration-time guard on the timing parameters.
    if (CLK_DIV < 2 || BLINKS < 1) begin : g_cfg_check
        $error("ox_result_sequencer: CLK_DIV must be >= 2 and BLINKS >= 1");
    end

    state_t             state_reg;
    logic               o_reg;
    logic               x_reg;
    logic [SCORE_W-1:0] score_o_reg;
    logic [SCORE_W-1:0] score_x_reg;

    // Exactly one winner; simultaneous pulses are a draw and change nothing.
    logic accept;
    assign accept = win_o_i ^ win_x_i;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

`ifdef OX_SEQ_BLINK_EN
    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = (BLINKS > 1) ? $clog2(BLINKS) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINKS - 1);

    logic          who_reg;   // 0 = player 1 (o), 1 = player 2 (x)
    logic          busy_reg;
    logic [PW-1:0] phase_reg;
    logic [BW-1:0] blink_reg;

    assign busy = busy_reg;
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            o_reg       <= 1'b0;
            x_reg       <= 1'b0;
            score_o_reg <= '0;
            score_x_reg <= '0;
`ifdef OX_SEQ_BLINK_EN
            who_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            phase_reg   <= '0;
            blink_reg   <= '0;
`endif
        end else if (clear_i) begin
            state_reg <= IDLE;
            o_reg     <= 1'b0;
            x_reg     <= 1'b0;
`ifdef OX_SEQ_BLINK_EN
            busy_reg  <= 1'b0;
            phase_reg <= '0;
            blink_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE, HOLD: begin
                    if (accept) begin
                        o_reg <= win_o_i;
                        x_reg <= win_x_i;
                        if (win_o_i) begin
                            score_o_reg <= sat_inc(score_o_reg);
                        end else begin
                            score_x_reg <= sat_inc(score_x_reg);
                        end
`ifdef OX_SEQ_BLINK_EN
                        who_reg   <= win_x_i;
                        state_reg <= SHOW_ON;
                        busy_reg  <= 1'b1;
                        phase_reg <= '0;
                        blink_reg <= '0;
`else
                        state_reg <= HOLD;
`endif
                    end
                end
`ifdef OX_SEQ_BLINK_EN
                SHOW_ON: begin
                    if (phase_reg == PHASE_LAST) begin
                        phase_reg <= '0;
                        state_reg <= SHOW_OFF;
                        o_reg     <= 1'b0;
                        x_reg     <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                SHOW_OFF: begin
                    if (phase_reg == PHASE_LAST) begin
                        phase_reg <= '0;
                        o_reg     <= ~who_reg;
                        x_reg     <= who_reg;
                        if (blink_reg == BLINK_LAST) begin
                            state_reg <= HOLD;
                            busy_reg  <= 1'b0;
                        end else begin
                            blink_reg <= blink_reg + 1'b1;
                            state_reg <= SHOW_ON;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign o       = o_reg;
    assign x       = x_reg;
    assign score_o = score_o_reg;
    assign score_x = score_x_reg;

endmodule

// File: tb/tb_ox_result_sequencer.sv
// Directed bench for ox_result_sequencer (CLK_DIV=4, BLINKS=2, SCORE_W=2); expected per-cycle
// output traces are queued when stimulus is driven and popped as each cycle's outputs are sampled.
module tb_ox_result_sequencer;

    localparam int C = 4;
    localparam int B = 2;
`ifdef OX_SEQ_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
    localparam int SEQ      = 2 * B * C;
`else
    localparam bit BLINK_EN = 1'b0;
    localparam int SEQ      = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       win_o_i = 1'b0;
    logic       win_x_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       o;
    logic       x;
    logic       busy;
    logic [1:0] score_o;
    logic [1:0] score_x;

    ox_result_sequencer #(
        .CLK_DIV(C),
        .BLINKS (B),
        .SCORE_W(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .win_o_i(win_o_i),
        .win_x_i(win_x_i),
        .clear_i(clear_i),
        .o      (o),
        .x      (x),
        .busy   (busy),
        .score_o(score_o),
        .score_x(score_x)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       o;
        logic       x;
        logic       busy;
        logic [1:0] so;
        logic [1:0] sx;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] exp_so = 2'd0;
    logic [1:0] exp_sx = 2'd0;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b0, exp_so, exp_sx});
        end
    endtask

    // Accepted win: bump the winner's score (saturating at 3), then queue n cycles of
    // blink pattern (C cycles on, C off, B times) followed by a steady hold.
    task automatic push_win(input bit px, input int n);
        logic on;
        logic bz;
        if (px) exp_sx = (exp_sx == 2'd3) ? 2'd3 : exp_sx + 2'd1;
        else    exp_so = (exp_so == 2'd3) ? 2'd3 : exp_so + 2'd1;
        for (int k = 1; k <= n; k++) begin
            on = 1'b1;
            bz = 1'b0;
            if (k <= SEQ) begin
                on = (((k - 1) / C) % 2) == 0;
                bz = 1'b1;
            end
            exp_q.push_back(exp_t'{on & ~px, on & px, bz, exp_so, exp_sx});
        end
    endtask

    // Drive inputs for one edge, then sample outputs 1 time unit after it.
    task automatic tick(input logic wo, input logic wx, input logic clr, input logic rst);
        exp_t e;
        win_o_i = wo;
        win_x_i = wx;
        clear_i = clr;
        reset   = rst;
        @(posedge clk);
        #1;
        cyc++;
        win_o_i = 1'b0;
        win_x_i = 1'b0;
        clear_i = 1'b0;
        reset   = 1'b0;
        if (exp_q.size() == 0) begin
            chk("queue_underflow", 2'd1, 2'd0);
        end else begin
            e = exp_q.pop_front();
            chk("o", {1'b0, o}, {1'b0, e.o});
            chk("x", {1'b0, x}, {1'b0, e.x});
            chk("busy", {1'b0, busy}, {1'b0, e.busy});
            chk("score_o", score_o, e.so);
            chk("score_x", score_x, e.sx);
        end
    endtask

    initial begin
        // Reset state
        push_idle(3);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Player-1 win, a dropped x pulse mid-blink, then hold
        push_win(1'b0, SEQ + 3);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= SEQ + 2; i++) begin
            tick(1'b0, BLINK_EN && (i == 3), 1'b0, 1'b0);
        end

        // Player-2 win accepted from HOLD restarts the sequence
        push_win(1'b1, SEQ + 3);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= SEQ + 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Clear back to dashes, then a draw in IDLE
        push_idle(2);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        push_idle(3);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Clear at the 2nd SHOW_ON cycle wins over a same-cycle x pulse
        push_win(1'b0, 2);
        push_idle(3);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-sequence overrides a same-cycle win and zeroes scores
        push_win(1'b1, 3);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        exp_so = 2'd0;
        exp_sx = 2'd0;
        push_idle(3);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Four player-1 results: score 1, 2, 3, 3, each still blinking and holding
        for (int w = 0; w < 4; w++) begin
            push_win(1'b0, SEQ + 2);
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 1; i <= SEQ + 1; i++) begin
                tick(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ox_result_sequencer.md
# ox_result_sequencer

Sequences the round-result indication on the player-result 7-segment display, which shows "P1 o" for player 1 (o), "P2 X" for player 2 (x) and dashes for no result. It accepts single-cycle win pulses from the game logic and keeps a saturating score per player. It drives the display's `o`/`x` select lines through a timed blink phase followed by a steady hold. It sits between the game FSM and the combinational 7-segment encoder.

## Interface
- `CLK_DIV`, 25_000_000: clock cycles per display phase (0.5 s at 50 MHz); must be ≥ 2.
- `BLINKS`, 3: number of on/off blink pairs before hold; must be ≥ 1.
- `SCORE_W`, 4: width of each score counter.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `win_o_i`  in  1  single-cycle pulse: player 1 (o) won the round.
- `win_x_i`  in  1  single-cycle pulse: player 2 (x) won the round.
- `clear_i`  in  1  return display to dashes; scores are kept.
- `o`  out  1  display select for player-1 result.
- `x`  out  1  display select for player-2 result.
- `busy`  out  1  high while blinking; win pulses are ignored.
- `score_o`  out  SCORE_W  player-1 wins, saturating.
- `score_x`  out  SCORE_W  player-2 wins, saturating.

## Operation
- **States:** IDLE, SHOW_ON, SHOW_OFF, HOLD. A `who` register selects o or x. A phase counter counts 0..CLK_DIV-1. A blink counter counts 0..BLINKS-1.
- **Outputs:**
  - IDLE: o=x=0.
  - SHOW_ON, HOLD: the selected output is 1 and the other is 0.
  - SHOW_OFF: o=x=0.
  - `busy` = (state is SHOW_ON or SHOW_OFF).
- **Accepting a result (IDLE or HOLD):**
  - Exactly one of `win_o_i`/`win_x_i` high → latch `who`, increment that player's score, go to SHOW_ON, clear the phase and blink counters.
  - Both high in the same cycle → draw: no score change, no state change.
- **Blinking:**
  - SHOW_ON → SHOW_OFF when the phase counter reaches CLK_DIV-1.
  - SHOW_OFF → SHOW_ON when the phase counter reaches CLK_DIV-1 and the blink counter is below BLINKS-1; the blink counter increments.
  - SHOW_OFF → HOLD when the phase counter reaches CLK_DIV-1 and the blink counter equals BLINKS-1.
  - Win pulses during SHOW_ON/SHOW_OFF are dropped; no score change.
- **HOLD** persists until `clear_i` or a new accepted win.
- **`clear_i`** in any state → IDLE next cycle; counters cleared, scores unchanged.
  - `clear_i` has priority over a same-cycle win pulse; that pulse is dropped.
- **Scores** saturate at 2^SCORE_W−1. Further wins still run the display sequence.

## Timing
- Reset values: state IDLE, o=0, x=0, busy=0, score_o=0, score_x=0, all counters 0.
- Reset asserted mid-sequence → all of the above on the next edge. Reset overrides `clear_i` and win pulses.
- Latency: a win sampled at edge N gives o/x, busy and the updated score visible from cycle N+1.
- Every SHOW_ON and SHOW_OFF phase lasts exactly CLK_DIV cycles.
- HOLD is entered at cycle N+1+2·BLINKS·CLK_DIV.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `OX_SEQ_BLINK_EN` defined: full SHOW_ON/SHOW_OFF blink sequence as above.
- `OX_SEQ_BLINK_EN` undefined:
  - An accepted win goes directly to HOLD at N+1.
  - SHOW_ON/SHOW_OFF, the phase counter and the blink counter are not built.
  - `busy` is tied 0.
  - BLINKS and CLK_DIV are unused.
  - Scores, draw, saturation and clear behaviour are unchanged.

## Test plan
All scenarios use CLK_DIV=4, BLINKS=2, SCORE_W=2.
1. Reset, then a `win_o_i` pulse at cycle 10:
   - o=1 cycles 11–14, 0 cycles 15–18, 1 cycles 19–22, 0 cycles 23–26; o=1 steady from 27.
   - x=0 throughout; busy=1 cycles 11–26; score_o=1 from 11.
2. `win_x_i` pulsed at cycle 13 during scenario 1's blink:
   - No effect: score_x=0 and the sequence is unchanged.
   - Then a `win_x_i` pulse in HOLD at cycle 30: x=1, o=0 from 31; score_x=1; the blink sequence restarts.
3. `win_o_i` and `win_x_i` high in the same cycle while in IDLE: state stays IDLE, o=x=0, scores unchanged.
4. Four accepted `win_o_i` results: score_o steps 1, 2, 3, 3; the 4th result still blinks and holds.
5. `clear_i` asserted at the 2nd SHOW_ON cycle, with a `win_x_i` pulse in the same cycle:
   - Next cycle: IDLE, o=x=0, busy=0.
   - score_x unchanged; scores otherwise retained.
   - Then `reset` → both scores 0.
6. Build without `OX_SEQ_BLINK_EN`: `win_x_i` at cycle 5 → x=1 steady from cycle 6, busy=0 throughout, score_x=1.
